// File: rtl/snake_pkg.sv
// Shared game-sequencer types, state encodings and parameter defaults.
// Also hosts the small constant helpers used to size counters.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int unsigned START_DIV_DEF      = 4;
  localparam int unsigned MIN_DIV_DEF        = 1;
  localparam int unsigned EATS_PER_LEVEL_DEF = 5;
  localparam int unsigned DEATH_FRAMES_DEF   = 120;
  localparam int unsigned BLINK_FRAMES_DEF   = 8;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Highest level reachable: min(3, start_div - min_div), zero if no headroom.
  function automatic int unsigned max_level(input int unsigned start_div,
                                            input int unsigned min_div);
    if (start_div <= min_div) return 0;
    if (start_div - min_div > 3) return 3;
    return start_div - min_div;
  endfunction

endpackage

// File: rtl/step_divider.sv
// Divides raw ticks down to snake step pulses; step is registered one cycle
// after the tick that completes a period of div ticks.
module step_divider #(
  parameter int unsigned DIV_W = 3
) (
  input  logic             clk_pix,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [DIV_W-1:0] div,
  input  logic             clear,
  input  logic             enable,
  output logic             step
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_step;

  // The >= guards against a count left above a freshly shortened period.
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (enable && tick) begin
      if (r_cnt >= div - DIV_W'(1)) begin
        r_cnt  <= '0;
        r_step <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_step <= 1'b0;
      end
    end else begin
      r_step <= 1'b0;
    end
  end

  assign step = r_step;

endmodule

// File: rtl/game_sequencer.sv
// Snake game control: IDLE/RUN/DYING/OVER sequencing, speed levels, death blink.
// A press in IDLE/OVER pulses game_clear for one cycle; RUN starts the cycle after.
module game_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned START_DIV      = START_DIV_DEF,
  parameter int unsigned MIN_DIV        = MIN_DIV_DEF,
  parameter int unsigned EATS_PER_LEVEL = EATS_PER_LEVEL_DEF,
  parameter int unsigned DEATH_FRAMES   = DEATH_FRAMES_DEF,
  parameter int unsigned BLINK_FRAMES   = BLINK_FRAMES_DEF
) (
  input  logic       clk_pix,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       frame_start,
  input  logic       btn_any_n,
  input  logic       self_hit,
  input  logic       wall_hit,
  input  logic       eat_evt,
  output logic       tick_run,
  output logic       game_clear,
  output logic [1:0] state,
  output logic       flash,
  output logic [1:0] level
);

  localparam int unsigned DIV_W   = cnt_width(START_DIV + MIN_DIV + 1);
  localparam int unsigned EAT_W   = cnt_width(EATS_PER_LEVEL);
  localparam int unsigned FRAME_W = cnt_width(DEATH_FRAMES + 1);
  localparam int unsigned LVL_MAX = max_level(START_DIV, MIN_DIV);

  state_t             r_state;
  logic               r_game_clear;
  logic               r_flash;
  logic               r_btn_prev;
  logic [1:0]         r_level;
  logic [EAT_W-1:0]   r_eat_cnt;
  logic [FRAME_W-1:0] r_frame_cnt;

  logic [FRAME_W-1:0] w_frame_nxt;
  logic [DIV_W-1:0]   w_div;
  logic               w_press;
  logic               w_hit;
  logic               w_div_en;

  assign w_press     = r_btn_prev & ~btn_any_n;
  assign w_hit       = tick_run & (self_hit | wall_hit);
  assign w_frame_nxt = r_frame_cnt + FRAME_W'(1);
  // A fatal step also stops the divider so no step leaks into DYING.
  assign w_div_en    = (r_state == ST_RUN) && !w_hit;

  always_comb begin
    w_div = DIV_W'(MIN_DIV);
    if (32'(r_level) + MIN_DIV < START_DIV) begin
      w_div = DIV_W'(START_DIV - 32'(r_level));
    end
  end

  step_divider #(
    .DIV_W (DIV_W)
  ) u_step_divider (
    .clk_pix (clk_pix),
    .reset_n (reset_n),
    .tick    (tick),
    .div     (w_div),
    .clear   (r_game_clear),
    .enable  (w_div_en),
    .step    (tick_run)
  );

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_game_clear <= 1'b0;
      r_flash      <= 1'b0;
      r_btn_prev   <= 1'b1;
      r_level      <= 2'd0;
      r_eat_cnt    <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_btn_prev   <= btn_any_n;
      r_game_clear <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          r_flash <= 1'b0;
          if (r_game_clear) begin
            r_state     <= ST_RUN;
            r_level     <= 2'd0;
            r_eat_cnt   <= '0;
            r_frame_cnt <= '0;
          end else if (w_press) begin
            r_game_clear <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_hit) begin
            r_state     <= ST_DYING;
            r_frame_cnt <= '0;
            r_flash     <= 1'b1;
          end else if (eat_evt) begin
            if (r_eat_cnt == EAT_W'(EATS_PER_LEVEL - 1)) begin
              r_eat_cnt <= '0;
              if (32'(r_level) < LVL_MAX) r_level <= r_level + 2'd1;
            end else begin
              r_eat_cnt <= r_eat_cnt + EAT_W'(1);
            end
          end
        end
        ST_DYING: begin
          if (frame_start) begin
            r_frame_cnt <= w_frame_nxt;
            if (w_frame_nxt == FRAME_W'(DEATH_FRAMES)) begin
              r_state <= ST_OVER;
              r_flash <= 1'b0;
            end else if ((32'(w_frame_nxt) % BLINK_FRAMES) == 32'd0) begin
              r_flash <= ~r_flash;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign game_clear = r_game_clear;
  assign flash      = r_flash;
  assign state      = r_state;
  assign level      = r_level;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter START_DIV, default 4: raw ticks per snake step at level 0.
REQ-002 SHALL have parameter MIN_DIV, default 1: lowest allowed ticks per step.
REQ-003 SHALL have parameter EATS_PER_LEVEL, default 5: eats needed per level-up.
REQ-004 SHALL have parameter DEATH_FRAMES, default 120: length of the DYING state, in frames.
REQ-005 SHALL have parameter BLINK_FRAMES, default 8: frames per flash half-period.
REQ-006 SHALL have port clk_pix  in  1  pixel clock; sole clock.
REQ-007 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port tick  in  1  raw base-rate tick pulse, one cycle wide.
REQ-009 SHALL have port frame_start  in  1  one-cycle pulse at pixel (0,0).
REQ-010 SHALL have port btn_any_n  in  1  synchronized, debounced, active-low OR of all direction buttons.
REQ-011 SHALL have port self_hit  in  1  head overlaps the body (from the snake core).
REQ-012 SHALL have port wall_hit  in  1  head is inside the border region.
REQ-013 SHALL have port eat_evt  in  1  one-cycle apple-eaten pulse.
REQ-014 SHALL have port tick_run  out  1  gated snake step pulse, one cycle wide.
REQ-015 SHALL have port game_clear  out  1  one-cycle soft clear for the snake core, apple and score.
REQ-016 SHALL have port state  out  2  encoding IDLE=00, RUN=01, DYING=10, OVER=11.
REQ-017 SHALL have port flash  out  1  renderer blink enable.
REQ-018 SHALL have port level  out  2  current speed level.

Function
REQ-019 SHALL detect a button press as a 1->0 transition of btn_any_n, using a registered previous value that resets to 1.
REQ-020 SHALL, in IDLE on a press: pulse game_clear for exactly 1 cycle, and enter RUN on the next cycle with level=0, div_cnt=0, eat_cnt=0.
REQ-021 SHALL, in RUN, increment div_cnt on each tick.
REQ-022 SHALL, in RUN, register tick_run high for 1 cycle, one cycle after the tick on which div_cnt equals div-1, and clear div_cnt to 0 on that tick.
REQ-023 SHALL compute div = max(START_DIV-level, MIN_DIV), using unsigned arithmetic with no underflow.
REQ-024 SHALL hold tick_run at 0 in every state other than RUN.
REQ-025 SHALL never assert tick_run in the cycle game_clear is high, nor in the cycle after it.
REQ-026 SHALL, in RUN, enter DYING on the next cycle when self_hit or wall_hit is high in a cycle where tick_run is high.
REQ-027 SHALL ignore hit inputs in cycles where tick_run is low.
REQ-028 SHALL count eat_evt in eat_cnt only while in RUN.
REQ-029 SHALL, when eat_evt arrives with eat_cnt=EATS_PER_LEVEL-1, reset eat_cnt to 0 and increment level, saturating at min(3, START_DIV-MIN_DIV).
REQ-030 SHALL give a qualifying hit priority over a simultaneous eat_evt: that eat does not change eat_cnt or level.
REQ-031 SHALL, on entry to DYING, clear frame_cnt to 0 and set flash=1.
REQ-032 SHALL, in DYING, increment frame_cnt on each frame_start.
REQ-033 SHALL, in DYING, toggle flash whenever frame_cnt mod BLINK_FRAMES reaches 0 after an increment.
REQ-034 SHALL, in DYING, enter OVER when frame_cnt reaches DEATH_FRAMES, forcing flash=0.
REQ-035 SHALL ignore button presses in DYING.
REQ-036 SHALL hold flash=0 in OVER.
REQ-037 SHALL, in OVER on a press, behave identically to IDLE on a press (game_clear pulse, then RUN with all counters cleared).
REQ-038 SHALL, when a press and a tick coincide in IDLE or OVER, discard that tick.
REQ-039 SHALL drive level and state only from registers.

Reset
REQ-040 SHALL, while reset_n=0, immediately force state=IDLE, tick_run=0, game_clear=0, flash=0, level=0, div_cnt=0, eat_cnt=0, frame_cnt=0, btn_prev=1, regardless of the clock.
REQ-041 SHALL, on reset mid-RUN or mid-DYING, abandon the game with no pending tick_run or game_clear after release.
REQ-042 SHALL, on the first clock after release, behave as IDLE.

Structure
REQ-043 SHALL place the state encodings (ST_IDLE..ST_OVER) and the default values of START_DIV, MIN_DIV, EATS_PER_LEVEL, DEATH_FRAMES and BLINK_FRAMES in shared package snake_pkg.
REQ-044 SHALL implement the div_cnt/tick_run logic as one sub-module, step_divider (inputs: tick, div, clear, enable; output: step pulse).
REQ-045 SHALL size frame_cnt as clog2(DEATH_FRAMES+1) bits and eat_cnt as clog2(EATS_PER_LEVEL) bits.

Verification
REQ-046 SHALL verify: reset, press, 8 ticks -> exactly one game_clear pulse, then tick_run on raw ticks 4 and 8 (START_DIV=4).
REQ-047 SHALL verify: 5 eat_evt in RUN -> level=1, tick_run every 3 ticks; 15 eats -> level=3, every tick; 20 eats -> level stays 3.
REQ-048 SHALL verify: self_hit with tick_run -> DYING next cycle, no further tick_run; self_hit without tick_run -> stays RUN.
REQ-049 SHALL verify: hit and eat_evt in same tick_run cycle with eat_cnt=4 -> DYING, level unchanged.
REQ-050 SHALL verify: DYING with 120 frame_starts -> flash toggles at frames 8, 16, ..., then OVER with flash=0; a press during DYING has no effect.
REQ-051 SHALL verify: reset_n pulsed low mid-RUN between clock edges -> outputs reach reset values asynchronously, and no tick_run follows release.
